uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (minimum 2).
REQ-002 Parameter DEPTH, default 4, transmit FIFO entries (power of two, minimum 2).
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port w_req  input  1  single-cycle write strobe from the CPU I/O write path.
REQ-006 Port w_data  input  8  byte to transmit, sampled when w_req is high.
REQ-007 Port w_busy  output  1  high when the FIFO is full; read back by the CPU as I/O status bit 0.
REQ-008 Port tx  output  1  serial line, 8N1 framing, idle high, registered.
REQ-009 Port tx_active  output  1  high while a frame is on the line (START, DATA or STOP).

Function
REQ-010 A write is accepted at a rising edge where w_req=1 and w_busy=0; w_data is pushed into the FIFO.
REQ-011 A write with w_req=1 and w_busy=1 is silently dropped; FIFO contents and count are unchanged.
REQ-012 w_busy is combinational from the registered FIFO count: 1 exactly when count==DEPTH.
REQ-013 FSM states are IDLE, START, DATA and STOP; the reset state is IDLE.
REQ-014 IDLE: tx=1. If the FIFO is non-empty at an edge, the FSM pops the head into the shift register, clears the bit counter and enters START.
REQ-015 START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA.
REQ-016 DATA: 8 bits sent LSB first, each held for exactly CLKS_PER_BIT cycles; after bit 7 the FSM enters STOP.
REQ-017 STOP: tx=1 for exactly CLKS_PER_BIT cycles.
REQ-018 At the end of STOP, if the FIFO is non-empty, the FSM pops and enters START directly, giving back-to-back frames with no idle gap; otherwise it returns to IDLE.
REQ-019 Latency: for a write accepted at edge E with the FSM in IDLE and the FIFO empty, tx is 0 from edge E+1.
REQ-020 When a push and a pop occur at the same edge, count is unchanged and both take effect.
REQ-021 A write accepted at the edge where a full FIFO pops is impossible, because w_busy was 1 at that edge; count becomes DEPTH-1.
REQ-022 FIFO read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits wide.
REQ-023 The baud counter counts 0..CLKS_PER_BIT-1 and is $clog2(CLKS_PER_BIT) bits wide; the bit counter is 3 bits wide.
REQ-024 tx_active is 1 exactly in START, DATA and STOP.

Reset
REQ-025 On rst=1 at an edge: state=IDLE, tx=1, FIFO emptied (count=0, pointers=0), baud and bit counters cleared.
REQ-026 Reset outputs: w_busy=0, tx_active=0.
REQ-027 A reset mid-frame aborts the frame; tx returns high at the next edge and any queued bytes are discarded.
REQ-028 A w_req coincident with rst=1 is ignored.

Structure
REQ-029 The FSM state enum typedef and the default CLKS_PER_BIT and DEPTH constants live in shared package lib_uart, alongside lib_cpu and lib_alu.
REQ-030 The FIFO is the sub-module uart_fifo, with ports clk, rst, push, push_data, pop, pop_data, count, full and empty; its read data comes from the head combinationally.
REQ-031 The FSM, baud counter and shift register are in uart_tx; no logic depends on any clock other than clk.

Verification (CLKS_PER_BIT=4, DEPTH=4)
REQ-032 Single byte: write 0x55 at edge E -> tx from E+1 is 0,1,0,1,0,1,0,1,0,1, each held 4 cycles (40 cycles total), then idle high; tx_active high for exactly 40 cycles.
REQ-033 Back-to-back: write 0xA3 then 0x0F on consecutive cycles -> two frames totalling 80 cycles, the second start bit immediately after the first stop bit, with no high gap beyond the stop bit.
REQ-034 Overflow: 6 writes on consecutive cycles from empty -> w_busy rises after the 5th accepted push (1 in flight plus 4 queued); the 6th write is dropped and exactly 5 frames are transmitted.
REQ-035 Full with simultaneous pop: FIFO full, hold w_req continuously -> no push at the pop edge (count becomes 3); the push is accepted one edge later (count returns to 4).
REQ-036 Reset mid-frame: rst=1 for 1 cycle during DATA bit 3 with 2 bytes queued -> tx=1, w_busy=0 and tx_active=0 next cycle; no further frames are sent.
REQ-037 Pointer wrap: 10 bytes (0x00..0x09) written with w_busy polling -> the received byte sequence matches the written order exactly.

Source files
------------

// File: rtl/lib_uart.sv
// Shared UART definitions: transmitter FSM state encoding and default sizing.
package lib_uart;

    // Transmitter frame states; the reset state is ST_IDLE
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // 100 MHz / 115200 baud
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;
    localparam int unsigned DEPTH_DEFAULT        = 4;
    localparam int unsigned DATA_BITS            = 8;

endpackage : lib_uart

// File: rtl/uart_fifo.sv
// Transmit byte FIFO. Head data is presented combinationally on pop_data.
// Pushes while full and pops while empty are ignored.
module uart_fifo
    import lib_uart::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             pop,
    output logic [7:0]       pop_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == CNT_W'(0));
    assign count     = count_q;
    assign pop_data  = mem_q[rd_ptr_q];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer, count and storage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 8'd0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= push_data;
            end
        end
    end

endmodule : uart_fifo

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small write FIFO. Frames are sent back to back
// while bytes are queued; tx is a registered output computed from next state.
module uart_tx
    import lib_uart::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned DEPTH        = DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       w_req,
    input  logic [7:0] w_data,
    output logic       w_busy,
    output logic       tx,
    output logic       tx_active
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    tx_state_e         state_q;
    tx_state_e         state_d;
    logic [BAUD_W-1:0] baud_q;
    logic [BAUD_W-1:0] baud_d;
    logic [2:0]        bit_q;
    logic [2:0]        bit_d;
    logic [7:0]        shift_q;
    logic [7:0]        shift_d;
    logic              tx_q;
    logic              tx_d;

    logic              baud_done_s;
    logic              fifo_push_s;
    logic              fifo_pop_s;
    logic [7:0]        fifo_data_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;

    // The FIFO also guards against overflow; gating here keeps the intent visible
    assign fifo_push_s = w_req & ~fifo_full_s;
    assign w_busy      = (fifo_count_s == CNT_W'(DEPTH));
    assign baud_done_s = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign tx          = tx_q;
    assign tx_active   = (state_q != ST_IDLE);

    uart_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push_s),
        .push_data (w_data),
        .pop       (fifo_pop_s),
        .pop_data  (fifo_data_s),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // State, counters, shift register and the registered serial output
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= BAUD_W'(0);
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state logic: each non-idle state lasts one full baud period
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_done_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (baud_done_s && (bit_q == 3'd7)) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_STOP: begin
                if (!baud_done_s) begin
                    state_d = ST_STOP;
                end else if (!fifo_empty_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: baud/bit counting, shifting, and FIFO pop when a frame begins
    always_comb begin
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        fifo_pop_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d = BAUD_W'(0);
                if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    shift_d    = fifo_data_s;
                    bit_d      = 3'd0;
                end else begin
                    fifo_pop_s = 1'b0;
                end
            end
            ST_START: begin
                if (baud_done_s) begin
                    baud_d = BAUD_W'(0);
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_done_s) begin
                    baud_d  = BAUD_W'(0);
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_done_s) begin
                    baud_d = BAUD_W'(0);
                    if (!fifo_empty_s) begin
                        fifo_pop_s = 1'b1;
                        shift_d    = fifo_data_s;
                        bit_d      = 3'd0;
                    end else begin
                        fifo_pop_s = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                baud_d = BAUD_W'(0);
                bit_d  = 3'd0;
            end
        endcase
    end

    // Output decode from the next state so tx changes on the same edge as the state
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_IDLE:  tx_d = 1'b1;
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            ST_STOP:  tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx with CLKS_PER_BIT=4, DEPTH=4.
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic       w_req;
    logic [7:0] w_data;
    logic       w_busy;
    logic       tx;
    logic       tx_active;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] rx_q [$];
    int         mon_cnt = -1;
    logic [7:0] mon_byte;

    uart_tx #(
        .CLKS_PER_BIT (4),
        .DEPTH        (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .w_req     (w_req),
        .w_data    (w_data),
        .w_busy    (w_busy),
        .tx        (tx),
        .tx_active (tx_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line level idx cycles into an 8N1 frame at 4 clocks per bit
    function automatic logic exp_bit(input logic [7:0] b, input int idx);
        int slot;
        slot = idx / 4;
        if (slot == 0) return 1'b0;
        else if (slot <= 8) return b[slot - 1];
        else return 1'b1;
    endfunction

    // Called just after the edge where the start bit appears; ends 40 cycles later
    task automatic check_frame(input string tag, input logic [7:0] b);
        for (int i = 0; i < 40; i++) begin
            check($sformatf("%s_tx%0d", tag, i), tx, exp_bit(b, i));
            check($sformatf("%s_act%0d", tag, i), tx_active, 1'b1);
            tick();
        end
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        int n;
        n = 0;
        while ((tx_active || w_busy) && n < max_cycles) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, (n < max_cycles), 1'b1);
    endtask

    // Serial receiver: samples mid-bit on the falling clock edge
    always @(negedge clk) begin
        if (rst) begin
            mon_cnt = -1;
        end else if (mon_cnt < 0) begin
            if (tx === 1'b0) begin
                mon_cnt  = 0;
                mon_byte = 8'd0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt >= 6 && mon_cnt <= 34 && (mon_cnt % 4) == 2) begin
                mon_byte[(mon_cnt - 6) / 4] = tx;
            end
            if (mon_cnt == 38) begin
                check("rx_stop_bit", tx, 1'b1);
                rx_q.push_back(mon_byte);
            end
            if (mon_cnt == 39) begin
                mon_cnt = -1;
            end
        end
    end

    initial begin
        int k;
        int n;
        logic [7:0] exp_q [$];

        // ---------------- reset ----------------
        rst = 1'b1; w_req = 1'b0; w_data = 8'd0;
        repeat (3) tick();
        check("rst_tx", tx, 1'b1);
        check("rst_busy", w_busy, 1'b0);
        check("rst_active", tx_active, 1'b0);
        rst = 1'b0;
        repeat (2) tick();

        // ---------------- single byte 0x55 ----------------
        rx_q.delete();
        w_req = 1'b1; w_data = 8'h55;
        tick();                         // edge E: accepted
        w_req = 1'b0;
        check("single_lat_tx", tx, 1'b1);
        check("single_busy", w_busy, 1'b0);
        tick();                         // edge E+1: start bit
        check_frame("single", 8'h55);
        check("single_end_tx", tx, 1'b1);
        check("single_end_act", tx_active, 1'b0);
        tick();
        check("single_rx_n", rx_q.size(), 1);
        if (rx_q.size() > 0) check("single_rx0", rx_q[0], 8'h55);

        // ---------------- back-to-back 0xA3, 0x0F ----------------
        rx_q.delete();
        w_req = 1'b1; w_data = 8'hA3;
        tick();
        w_data = 8'h0F;
        tick();
        w_req = 1'b0;
        check_frame("b2b_a", 8'hA3);
        check_frame("b2b_b", 8'h0F);
        check("b2b_end_tx", tx, 1'b1);
        check("b2b_end_act", tx_active, 1'b0);
        tick();
        check("b2b_rx_n", rx_q.size(), 2);

        // ---------------- overflow: 6 writes ----------------
        rx_q.delete();
        for (int i = 0; i < 6; i++) begin
            w_req = 1'b1; w_data = 8'(8'h11 * (i + 1));
            tick();
            check($sformatf("ovf_busy%0d", i), w_busy, (i >= 4) ? 1'b1 : 1'b0);
        end
        w_req = 1'b0;
        wait_idle("ovf", 400);
        repeat (2) tick();
        check("ovf_rx_n", rx_q.size(), 5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
            check($sformatf("ovf_rx%0d", i), rx_q[i], 8'(8'h11 * (i + 1)));
        end

        // ---------------- full with simultaneous pop ----------------
        rx_q.delete();
        for (int i = 0; i < 5; i++) begin
            w_req = 1'b1; w_data = 8'(8'hA0 + i);
            tick();
        end
        check("fp_full", w_busy, 1'b1);
        w_data = 8'hC5;                 // w_req held high from here
        k = -1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (!w_busy) begin
                k = i;
                break;
            end
        end
        check("fp_pop_edge", k, 36);
        tick();
        check("fp_refill", w_busy, 1'b1);
        w_req = 1'b0;
        wait_idle("fp", 400);
        repeat (2) tick();
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hC5};
        check("fp_rx_n", rx_q.size(), 6);
        for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
            check($sformatf("fp_rx%0d", i), rx_q[i], exp_q[i]);
        end

        // ---------------- reset mid-frame ----------------
        rx_q.delete();
        for (int i = 0; i < 3; i++) begin
            w_req = 1'b1; w_data = 8'(8'h30 + i);
            tick();
        end
        w_req = 1'b0;                   // just after E+2
        repeat (16) tick();             // just after E+18: DATA bit 3
        check("mr_pre_act", tx_active, 1'b1);
        rst = 1'b1; w_req = 1'b1; w_data = 8'h99;
        tick();                         // E+19: reset
        rst = 1'b0; w_req = 1'b0;
        check("mr_tx", tx, 1'b1);
        check("mr_busy", w_busy, 1'b0);
        check("mr_active", tx_active, 1'b0);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx !== 1'b1 || tx_active !== 1'b0) n++;
        end
        check("mr_quiet_cycles", n, 0);
        check("mr_rx_n", rx_q.size(), 0);

        // ---------------- pointer wrap: 10 bytes with polling ----------------
        rx_q.delete();
        for (int b = 0; b < 10; b++) begin
            n = 0;
            while (w_busy && n < 200) begin
                tick();
                n++;
            end
            check($sformatf("wrap_poll%0d", b), (n < 200), 1'b1);
            w_req = 1'b1; w_data = 8'(b);
            tick();
            w_req = 1'b0;
        end
        repeat (2) tick();
        wait_idle("wrap", 600);
        repeat (2) tick();
        check("wrap_rx_n", rx_q.size(), 10);
        for (int i = 0; i < 10 && i < rx_q.size(); i++) begin
            check($sformatf("wrap_rx%0d", i), rx_q[i], 8'(i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_uart_tx
